// File: rtl/csr_regfile_pkg.sv
// ---------------------------------------------------------------------------
// csr_regfile_pkg
//
// Shared definitions for the machine-mode CSR storage array and the
// write-back CSR control stage that drives it:
//   - 12-bit CSR address constants
//   - the constant misa value (RV32I)
//   - mcause exception codes used by the control stage
//   - a small write-port resolution helper that applies "port 2 wins"
//     when both write ports target the same CSR address
// ---------------------------------------------------------------------------
package csr_regfile_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // misa: MXL=1 (32-bit), extension bit I set
  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // mcause codes shared with the control stage
  localparam logic [31:0] ECALL_M = 32'h0000_000b;

  // Resolved write for a single CSR: whether it is written this cycle and
  // with what data.
  typedef struct packed {
    logic        en;
    logic [31:0] data;
  } csrWrite_t;

  // Port 2 carries the trap/return side-write, so when both ports hit the
  // same address in one cycle the port-2 data is the one that commits.
  function automatic csrWrite_t resolveWrite(
    input logic [11:0] addr,
    input logic [11:0] waddr1,
    input logic [31:0] wdata1,
    input logic        wena1,
    input logic [11:0] waddr2,
    input logic [31:0] wdata2,
    input logic        wena2
  );
    csrWrite_t result;
    logic      hit1;
    logic      hit2;
    hit1        = wena1 && (waddr1 == addr);
    hit2        = wena2 && (waddr2 == addr);
    result.en   = hit1 || hit2;
    result.data = hit2 ? wdata2 : wdata1;
    return result;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64
//
// 64-bit free-running counter backing mcycle/minstret (and their high
// halves). Each 32-bit half can be loaded independently by software.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset, clears the counter
//   incEn_i       increment by one this cycle
//   loadLo_i      load bits [31:0] from loadLoData_i
//   loadHi_i      load bits [63:32] from loadHiData_i
//   loadLoData_i  data for the low half
//   loadHiData_i  data for the high half
//   count_o       current 64-bit count
// ---------------------------------------------------------------------------
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        incEn_i,
  input  logic        loadLo_i,
  input  logic        loadHi_i,
  input  logic [31:0] loadLoData_i,
  input  logic [31:0] loadHiData_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // A software load of either half suppresses the increment for the whole
  // cycle, so the untouched half holds and no carry crosses into it.
  always_comb begin
    count_d = count_q;
    if (loadLo_i || loadHi_i) begin
      if (loadLo_i) begin
        count_d[31:0] = loadLoData_i;
      end
      if (loadHi_i) begin
        count_d[63:32] = loadHiData_i;
      end
    end else if (incEn_i) begin
      count_d = count_q + 64'd1;
    end
  end

  // Counter state register; reset has priority over load and increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 64'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_regfile.sv
// ---------------------------------------------------------------------------
// csr_regfile
//
// Machine-mode CSR storage array, downstream of the write-back CSR control
// logic. Accepts a general write port (port 1) and a trap/return side-write
// port (port 2), serves a combinational read port, and exports mtvec/mepc to
// the fetch redirect path.
//
// Configuration macro:
//   CSR_COUNTERS_EN  when defined, mcycle/mcycleh/minstret/minstreth are
//                    implemented; when undefined those addresses read 0 with
//                    o_illegal=1, writes to them are dropped and i_retire is
//                    ignored.
//
// Parameters:
//   MHARTID        value returned by mhartid
//   MSTATUS_RST    reset value of mstatus
//   MSTATUS_WMASK  writable bits of mstatus
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   i_waddr1   port-1 write address     i_wdata1  port-1 write data
//   i_wena1    port-1 write enable
//   i_waddr2   port-2 write address     i_wdata2  port-2 write data
//   i_wena2    port-2 write enable
//   i_raddr    read address
//   i_retire   one instruction retired this cycle
//   o_rdata    read data (combinational from i_raddr)
//   o_illegal  i_raddr is not an implemented CSR
//   o_mtvec    current mtvec
//   o_mepc     current mepc
// ---------------------------------------------------------------------------
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] MHARTID       = 32'h0,
  parameter logic [31:0] MSTATUS_RST   = 32'h0000_1800,
  parameter logic [31:0] MSTATUS_WMASK = 32'h0000_1888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_waddr1,
  input  logic [31:0] i_wdata1,
  input  logic        i_wena1,
  input  logic [11:0] i_waddr2,
  input  logic [31:0] i_wdata2,
  input  logic        i_wena2,
  input  logic [11:0] i_raddr,
  input  logic        i_retire,
  output logic [31:0] o_rdata,
  output logic        o_illegal,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  logic [31:0] mstatus_q,  mstatus_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;

  csrWrite_t wrMstatus;
  csrWrite_t wrMtvec;
  csrWrite_t wrMscratch;
  csrWrite_t wrMepc;
  csrWrite_t wrMcause;

  // Per-CSR write resolution; unimplemented and read-only addresses simply
  // never match a target here, which is how those writes get dropped.
  assign wrMstatus  = resolveWrite(CSR_MSTATUS,  i_waddr1, i_wdata1, i_wena1,
                                   i_waddr2, i_wdata2, i_wena2);
  assign wrMtvec    = resolveWrite(CSR_MTVEC,    i_waddr1, i_wdata1, i_wena1,
                                   i_waddr2, i_wdata2, i_wena2);
  assign wrMscratch = resolveWrite(CSR_MSCRATCH, i_waddr1, i_wdata1, i_wena1,
                                   i_waddr2, i_wdata2, i_wena2);
  assign wrMepc     = resolveWrite(CSR_MEPC,     i_waddr1, i_wdata1, i_wena1,
                                   i_waddr2, i_wdata2, i_wena2);
  assign wrMcause   = resolveWrite(CSR_MCAUSE,   i_waddr1, i_wdata1, i_wena1,
                                   i_waddr2, i_wdata2, i_wena2);

  // Next-state for the plain storage CSRs. mstatus keeps non-writable bits
  // from the old value (which are always their reset value), and mtvec/mepc
  // are kept word aligned since only direct-mode vectors are supported.
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (wrMstatus.en) begin
      mstatus_d = (wrMstatus.data & MSTATUS_WMASK) | (mstatus_q & ~MSTATUS_WMASK);
    end
    if (wrMtvec.en) begin
      mtvec_d = {wrMtvec.data[31:2], 2'b00};
    end
    if (wrMscratch.en) begin
      mscratch_d = wrMscratch.data;
    end
    if (wrMepc.en) begin
      mepc_d = {wrMepc.data[31:2], 2'b00};
    end
    if (wrMcause.en) begin
      mcause_d = wrMcause.data;
    end
  end

  // Storage registers; reset has priority over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= 32'h0;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csrWrite_t   wrMcycle;
  csrWrite_t   wrMcycleh;
  csrWrite_t   wrMinstret;
  csrWrite_t   wrMinstreth;
  logic [63:0] mcycleCount;
  logic [63:0] minstretCount;

  assign wrMcycle    = resolveWrite(CSR_MCYCLE,    i_waddr1, i_wdata1, i_wena1,
                                    i_waddr2, i_wdata2, i_wena2);
  assign wrMcycleh   = resolveWrite(CSR_MCYCLEH,   i_waddr1, i_wdata1, i_wena1,
                                    i_waddr2, i_wdata2, i_wena2);
  assign wrMinstret  = resolveWrite(CSR_MINSTRET,  i_waddr1, i_wdata1, i_wena1,
                                    i_waddr2, i_wdata2, i_wena2);
  assign wrMinstreth = resolveWrite(CSR_MINSTRETH, i_waddr1, i_wdata1, i_wena1,
                                    i_waddr2, i_wdata2, i_wena2);

  csr_counter64 mcycleCounter (
    .clk_i        (clk),
    .rst_i        (rst),
    .incEn_i      (1'b1),
    .loadLo_i     (wrMcycle.en),
    .loadHi_i     (wrMcycleh.en),
    .loadLoData_i (wrMcycle.data),
    .loadHiData_i (wrMcycleh.data),
    .count_o      (mcycleCount)
  );

  csr_counter64 minstretCounter (
    .clk_i        (clk),
    .rst_i        (rst),
    .incEn_i      (i_retire),
    .loadLo_i     (wrMinstret.en),
    .loadHi_i     (wrMinstreth.en),
    .loadLoData_i (wrMinstret.data),
    .loadHiData_i (wrMinstreth.data),
    .count_o      (minstretCount)
  );
`else
  logic unusedRetire;
  assign unusedRetire = i_retire;
`endif

  // Read mux; anything not listed is unimplemented and reads as zero.
  always_comb begin
    o_rdata   = 32'h0;
    o_illegal = 1'b0;
    case (i_raddr)
      CSR_MSTATUS:   o_rdata = mstatus_q;
      CSR_MISA:      o_rdata = MISA_VALUE;
      CSR_MTVEC:     o_rdata = mtvec_q;
      CSR_MSCRATCH:  o_rdata = mscratch_q;
      CSR_MEPC:      o_rdata = mepc_q;
      CSR_MCAUSE:    o_rdata = mcause_q;
      CSR_MVENDORID: o_rdata = 32'h0;
      CSR_MHARTID:   o_rdata = MHARTID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    o_rdata = mcycleCount[31:0];
      CSR_MCYCLEH:   o_rdata = mcycleCount[63:32];
      CSR_MINSTRET:  o_rdata = minstretCount[31:0];
      CSR_MINSTRETH: o_rdata = minstretCount[63:32];
`endif
      default: begin
        o_rdata   = 32'h0;
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_mtvec = mtvec_q;
  assign o_mepc  = mepc_q;

endmodule

// File: tb/tb_csr_regfile.sv
// ---------------------------------------------------------------------------
// tb_csr_regfile
//
// Directed bench for csr_regfile. Expected values are hand computed. The
// counter section is compiled only when CSR_COUNTERS_EN is defined; without
// it the counter addresses are expected to be illegal.
// ---------------------------------------------------------------------------
module tb_csr_regfile;

  localparam logic [31:0] HART_ID = 32'h0000_0005;

  logic        clk;
  logic        rst;
  logic [11:0] waddr1;
  logic [31:0] wdata1;
  logic        wena1;
  logic [11:0] waddr2;
  logic [31:0] wdata2;
  logic        wena2;
  logic [11:0] raddr;
  logic        retire;
  logic [31:0] rdata;
  logic        illegal;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  int checkCount = 0;
  int errorCount = 0;

  csr_regfile #(
    .MHARTID       (HART_ID),
    .MSTATUS_RST   (32'h0000_1800),
    .MSTATUS_WMASK (32'h0000_1888)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_waddr1  (waddr1),
    .i_wdata1  (wdata1),
    .i_wena1   (wena1),
    .i_waddr2  (waddr2),
    .i_wdata2  (wdata2),
    .i_wena2   (wena2),
    .i_raddr   (raddr),
    .i_retire  (retire),
    .o_rdata   (rdata),
    .o_illegal (illegal),
    .o_mtvec   (mtvec),
    .o_mepc    (mepc)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Drive both write ports for the upcoming clock edge.
  task automatic applyStimulus(input logic [11:0] a1, input logic [31:0] d1,
                               input logic e1, input logic [11:0] a2,
                               input logic [31:0] d2, input logic e2);
    waddr1 = a1;
    wdata1 = d1;
    wena1  = e1;
    waddr2 = a2;
    wdata2 = d2;
    wena2  = e2;
  endtask

  task automatic idleWrites();
    applyStimulus(12'h000, 32'h0, 1'b0, 12'h000, 32'h0, 1'b0);
  endtask

  // Advance past the next rising edge so outputs are sampled away from it.
  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  // Present a read address and check both read outputs.
  task automatic checkRead(input string tag, input logic [11:0] addr,
                           input logic [31:0] expData, input logic expIllegal);
    raddr = addr;
    #1;
    checkOutput({tag, ".data"}, rdata, expData);
    checkOutput({tag, ".illegal"}, {31'h0, illegal}, {31'h0, expIllegal});
  endtask

  logic [11:0] rstAddr [8];
  logic [31:0] rstData [8];

  initial begin
    rst    = 1'b1;
    raddr  = 12'h000;
    retire = 1'b0;
    idleWrites();
    rstAddr = '{12'h300, 12'h301, 12'h305, 12'h340,
                12'h341, 12'h342, 12'hF11, 12'hF14};
    rstData = '{32'h0000_1800, 32'h4000_0100, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, HART_ID};

    // Reset state, read while reset is held so nothing can advance.
    repeat (3) clockEdge();
    for (int i = 0; i < 8; i++) begin
      checkRead($sformatf("reset_%03h", rstAddr[i]), rstAddr[i], rstData[i], 1'b0);
    end
    checkOutput("reset_mtvec_out", mtvec, 32'h0);
    checkOutput("reset_mepc_out", mepc, 32'h0);
`ifdef CSR_COUNTERS_EN
    checkRead("reset_mcycle", 12'hB00, 32'h0, 1'b0);
    checkRead("reset_minstreth", 12'hB82, 32'h0, 1'b0);
`endif
    rst = 1'b0;

    // mtvec write: low bits cleared, no same-cycle bypass.
    applyStimulus(12'h305, 32'h8000_0103, 1'b1, 12'h000, 32'h0, 1'b0);
    checkRead("mtvec_same_cycle", 12'h305, 32'h0, 1'b0);
    clockEdge();
    idleWrites();
    checkOutput("mtvec_out", mtvec, 32'h8000_0100);
    checkRead("mtvec_read", 12'h305, 32'h8000_0100, 1'b0);

    // Different addresses on both ports in one cycle both commit.
    applyStimulus(12'h341, 32'h8000_0010, 1'b1, 12'h342, 32'h0000_000b, 1'b1);
    clockEdge();
    idleWrites();
    checkOutput("mepc_out", mepc, 32'h8000_0010);
    checkRead("mcause_read", 12'h342, 32'h0000_000b, 1'b0);

    // mepc alignment
    applyStimulus(12'h341, 32'h1234_5677, 1'b1, 12'h000, 32'h0, 1'b0);
    clockEdge();
    idleWrites();
    checkOutput("mepc_align", mepc, 32'h1234_5674);

    // Same address on both ports: port 2 wins.
    applyStimulus(12'h340, 32'h1111_1111, 1'b1, 12'h340, 32'h2222_2222, 1'b1);
    clockEdge();
    idleWrites();
    checkRead("mscratch_port2_wins", 12'h340, 32'h2222_2222, 1'b0);

    // mstatus write mask, both directions.
    applyStimulus(12'h000, 32'h0, 1'b0, 12'h300, 32'hFFFF_FFFF, 1'b1);
    clockEdge();
    idleWrites();
    checkRead("mstatus_all_ones", 12'h300, 32'h0000_1888, 1'b0);
    applyStimulus(12'h300, 32'h0000_0080, 1'b1, 12'h000, 32'h0, 1'b0);
    clockEdge();
    idleWrites();
    checkRead("mstatus_mpie_only", 12'h300, 32'h0000_0080, 1'b0);

    // Read-only and unimplemented writes are dropped.
    applyStimulus(12'h301, 32'hDEAD_BEEF, 1'b1, 12'h7C0, 32'hDEAD_BEEF, 1'b1);
    clockEdge();
    idleWrites();
    checkRead("misa_readonly", 12'h301, 32'h4000_0100, 1'b0);
    checkRead("unimpl_7c0", 12'h7C0, 32'h0, 1'b1);
    checkOutput("mtvec_held", mtvec, 32'h8000_0100);

`ifdef CSR_COUNTERS_EN
    // mcycle load across the 32-bit boundary: FFFFFFFE -> FFFFFFFF -> carry.
    applyStimulus(12'hB00, 32'hFFFF_FFFE, 1'b1, 12'hB80, 32'h0, 1'b1);
    clockEdge();
    idleWrites();
    checkRead("mcycle_loaded", 12'hB00, 32'hFFFF_FFFE, 1'b0);
    clockEdge();
    clockEdge();
    checkRead("mcycleh_carry", 12'hB80, 32'h0000_0001, 1'b0);
    checkRead("mcycle_wrapped", 12'hB00, 32'h0, 1'b0);

    // Three retire pulses with gaps in between.
    checkRead("minstret_idle", 12'hB02, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1;
      clockEdge();
      retire = 1'b0;
      clockEdge();
    end
    checkRead("minstret_three", 12'hB02, 32'h3, 1'b0);
    checkRead("minstreth_zero", 12'hB82, 32'h0, 1'b0);

    // Reset mid-count clears both counters, even with a write pending.
    retire = 1'b1;
    applyStimulus(12'hB02, 32'h0000_0055, 1'b1, 12'h000, 32'h0, 1'b0);
    rst = 1'b1;
    clockEdge();
    idleWrites();
    retire = 1'b0;
    checkRead("rst_mcycle", 12'hB00, 32'h0, 1'b0);
    checkRead("rst_minstret", 12'hB02, 32'h0, 1'b0);
    rst = 1'b0;
`else
    // Counters absent: addresses are illegal and writes vanish.
    applyStimulus(12'hB00, 32'h1234_5678, 1'b1, 12'h000, 32'h0, 1'b0);
    retire = 1'b1;
    clockEdge();
    idleWrites();
    retire = 1'b0;
    checkRead("nocnt_mcycle", 12'hB00, 32'h0, 1'b1);
    checkRead("nocnt_minstret", 12'hB02, 32'h0, 1'b1);
    rst = 1'b1;
    clockEdge();
    rst = 1'b0;
`endif

    // After a reset pulse the redirect outputs go back to zero.
    checkOutput("rst_mtvec_out", mtvec, 32'h0);
    checkOutput("rst_mepc_out", mepc, 32'h0);
    checkRead("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
